add_arbiter_seq: RTL and testbench

ADD_ARBITER_SEQ -- requirements
Module: add_arbiter_seq

---
 rtl/add_arbiter_seq.sv | 144 ++++++++++++++
 tb/tb_add_arbiter_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter_seq.sv
// add_arbiter_seq: two requesters share one WIDTH-bit adder that performs a
// WORDS-word addition, one word per cycle, least significant word first.
// Round-robin arbitration between the two requesters.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req[1:0]        per-requester operation request
//   a0, b0, a1, b1  per-requester operands, word 0 least significant
//   cin[1:0]        per-requester initial carry-in
//   grant[1:0]      one-hot owner of the adder, 0 when idle
//   busy            high while an operation is in RUN or DONE
//   done[1:0]       one-cycle completion pulse to the owner
//   sum, cout       multi-word result and final carry-out
module add_arbiter_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  input  logic [WORDS*WIDTH-1:0] a0,
  input  logic [WORDS*WIDTH-1:0] b0,
  input  logic [WORDS*WIDTH-1:0] a1,
  input  logic [WORDS*WIDTH-1:0] b1,
  input  logic [1:0]             cin,
  output logic [1:0]             grant,
  output logic                   busy,
  output logic [1:0]             done,
  output logic [WORDS*WIDTH-1:0] sum,
  output logic                   cout
);

  localparam int unsigned OpW  = WORDS * WIDTH;
  // Wide enough to hold WORDS so idx never wraps after the last word.
  localparam int unsigned IdxW = $clog2(WORDS + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      done_q, done_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;   // requester served most recently
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [OpW-1:0]  sum_q, sum_d;

  logic [OpW-1:0]   a_sel, b_sel;
  logic [WIDTH-1:0] a_word, b_word, word_sum;
  logic             word_carry;

  assign a_sel = owner_q ? a1 : a0;
  assign b_sel = owner_q ? b1 : b0;

  // Word select with constant slices only; idx may equal WORDS outside RUN.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_word = a_sel[i*WIDTH +: WIDTH];
        b_word = b_sel[i*WIDTH +: WIDTH];
      end
    end
  end

  // The single shared word adder.
  assign {word_carry, word_sum} = {1'b0, a_word} + {1'b0, b_word} + {{WIDTH{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    owner_d = owner_q;
    last_d  = last_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          // On a tie the requester not served last wins.
          owner_d = (req == 2'b11) ? ~last_q : req[1];
          grant_d = owner_d ? 2'b10 : 2'b01;
          carry_d = cin[owner_d];
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IdxW'(i)) sum_d[i*WIDTH +: WIDTH] = word_sum;
        end
        carry_d = word_carry;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          cout_d  = word_carry;
          done_d  = grant_q;
          state_d = StDone;
        end
      end
      StDone: begin
        last_d  = owner_q;
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // pretend requester 1 went last so requester 0 wins a tie
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != StIdle);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_add_arbiter_seq.sv
// Self-checking bench for add_arbiter_seq (WIDTH=32, WORDS=4). Expected
// results come from full-width arithmetic and a last-served arbitration model.
module tb_add_arbiter_seq;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned OW = W * N;

  logic          clk;
  logic          rst;
  logic [1:0]    req;
  logic [OW-1:0] a0, b0, a1, b1;
  logic [1:0]    cin;
  logic [1:0]    grant;
  logic          busy;
  logic [1:0]    done;
  logic [OW-1:0] sum;
  logic          cout;

  int checks = 0;
  int errors = 0;

  logic          last_m;   // model: requester served most recently
  logic [OW-1:0] exp_sum;
  logic          exp_cout;

  add_arbiter_seq #(
    .WIDTH(W),
    .WORDS(N)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a0   (a0),
    .b0   (b0),
    .a1   (a1),
    .b1   (b1),
    .cin  (cin),
    .grant(grant),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] rand_op();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts an operation in an IDLE cycle and follows it to its done pulse.
  task automatic do_op(input logic [1:0] r, input bit drop_early, input bit scramble);
    logic       owner;
    logic [1:0] oh;
    logic [OW:0] full;
    int         lat;
    owner = (r == 2'b11) ? ~last_m : r[1];
    oh    = owner ? 2'b10 : 2'b01;
    full  = owner ? ({1'b0, a1} + {1'b0, b1} + cin[1]) : ({1'b0, a0} + {1'b0, b0} + cin[0]);
    exp_sum  = full[OW-1:0];
    exp_cout = full[OW];
    req = r;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (drop_early && k == 2) req[owner] = 1'b0;
      if (scramble) begin
        if (owner) begin
          a0 = rand_op();
          b0 = rand_op();
        end else begin
          a1 = rand_op();
          b1 = rand_op();
        end
        req[~owner] = 1'($urandom);
      end
      check("grant", {126'd0, grant}, {126'd0, oh});
      check("busy", {127'd0, busy}, 128'd1);
      if (done != 2'b00) begin
        lat = k;
        break;
      end
    end
    check("latency", OW'(lat), OW'(N + 1));
    check("done", {126'd0, done}, {126'd0, oh});
    check("sum", sum, exp_sum);
    check("cout", {127'd0, cout}, {127'd0, exp_cout});
    last_m = owner;
  endtask

  // One IDLE cycle after DONE: adder released, result held.
  task automatic idle_gap();
    req = 2'b00;
    step();
    check("idle_grant", {126'd0, grant}, 128'd0);
    check("idle_busy", {127'd0, busy}, 128'd0);
    check("idle_done", {126'd0, done}, 128'd0);
    check("hold_sum", sum, exp_sum);
    check("hold_cout", {127'd0, cout}, {127'd0, exp_cout});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    step();
    rst = 1'b0;
    last_m = 1'b1;
    exp_sum = '0;
    exp_cout = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    cin = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    step();
    step();
    check("rst_grant", {126'd0, grant}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {126'd0, done}, 128'd0);
    check("rst_sum", sum, 128'd0);
    check("rst_cout", {127'd0, cout}, 128'd0);
    rst = 1'b0;
    last_m = 1'b1;

    // All-ones plus one: carry ripples through every word.
    a0 = '1; b0 = 128'd1; cin = 2'b00;
    do_op(2'b01, 1'b0, 1'b0);
    check("ones_sum", sum, 128'd0);
    check("ones_cout", {127'd0, cout}, 128'd1);
    idle_gap();

    // Held tie after reset: 0 first, then 1 at the earliest slot.
    do_reset();
    a0 = rand_op(); b0 = rand_op(); a1 = rand_op(); b1 = rand_op(); cin = 2'($urandom);
    do_op(2'b11, 1'b0, 1'b0);
    step();
    check("tie_gap_grant", {126'd0, grant}, 128'd0);
    do_op(2'b11, 1'b0, 1'b0);
    idle_gap();

    // Carry-in only.
    a1 = '0; b1 = '0; cin = 2'b10;
    do_op(2'b10, 1'b0, 1'b0);
    check("cin_sum", sum, 128'd1);
    idle_gap();

    // Inter-word carry.
    a0 = 128'hFFFF_FFFF; b0 = 128'd1; cin = 2'b00;
    do_op(2'b01, 1'b0, 1'b0);
    check("xword_sum", sum, 128'h1_0000_0000);
    idle_gap();

    // Requester drops req mid-operation.
    a0 = rand_op(); b0 = rand_op(); cin = 2'($urandom);
    do_op(2'b01, 1'b1, 1'b0);
    idle_gap();

    // Reset in the second RUN cycle aborts without done.
    a0 = rand_op(); b0 = rand_op();
    req = 2'b01;
    step();
    step();
    do_reset();
    check("abort_grant", {126'd0, grant}, 128'd0);
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_done", {126'd0, done}, 128'd0);
    check("abort_sum", sum, 128'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("abort_no_done", {126'd0, done}, 128'd0);
    end
    a0 = rand_op(); b0 = rand_op(); cin = 2'($urandom);
    do_op(2'b01, 1'b0, 1'b0);
    idle_gap();

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      a0 = ($urandom_range(0, 3) == 0) ? '1 : rand_op();
      b0 = rand_op();
      a1 = ($urandom_range(0, 3) == 0) ? '1 : rand_op();
      b1 = rand_op();
      cin = 2'($urandom);
      do_op(2'($urandom_range(1, 3)), 1'($urandom), 1'b1);
      idle_gap();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
